// File: rtl/fnd_pkg.sv
// Shared types and constants for the BCD scan display controller.
package fnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Active-low pgfe_dcba patterns, entry 15 first.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational 4-bit to active-low 7-segment pattern decoder.
module seg7_hex_dec
  import fnd_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [7:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/fnd_bcd_scan_ctrl.sv
// Sequential double-dabble binary-to-BCD converter with a multiplexed
// common-anode 7-segment scan driver.
module fnd_bcd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int BIN_W       = 14,
  parameter int DIGITS      = 4,
  parameter int REFRESH_CNT = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  load,
  output logic                  busy,
  output logic                  valid,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7:0]            seg_7,
  output logic [DIGITS-1:0]     com
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam int RW = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  state_e           state_q;
  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic [SW-1:0]    scr_q, scr_d, scr_adj;
  logic [CW-1:0]    cnt_q;
  logic             ovf_pend_q, ovf_q, valid_q, busy_q;
  logic [SW-1:0]    bcd_q;

  // Add-3 correction on every nibble, then shift the whole register pair;
  // bits leaving the top of the scratch are dropped (mod 10^DIGITS).
  always_comb begin
    scr_adj = '0;
    for (int i = 0; i < DIGITS; i++)
      scr_adj[4*i +: 4] = (scr_q[4*i +: 4] > 4'd4) ? scr_q[4*i +: 4] + 4'd3
                                                   : scr_q[4*i +: 4];
    {scr_d, shreg_d} = {scr_adj, shreg_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      bcd_q      <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (load) begin
          shreg_q    <= bin;
          scr_q      <= '0;
          cnt_q      <= CW'(BIN_W);
          ovf_pend_q <= 64'(bin) > MAX_VAL;
          busy_q     <= 1'b1;
          state_q    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          scr_q   <= scr_d;
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          bcd_q   <= scr_q;
          ovf_q   <= ovf_pend_q;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [RW-1:0]     ref_q;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] com_q, com_d;
  logic [7:0]        seg_q, seg_d, hex_seg;
  logic [3:0]        dig;
  logic              blank, zacc;

  assign idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
  assign com_d = ~(DIGITS'(1) << idx_d);

  // Pattern for the digit about to be selected, so seg_7 and com move together.
  always_comb begin
    dig   = '0;
    blank = 1'b0;
    zacc  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zacc = zacc & (bcd_q[4*i +: 4] == 4'd0);
      if (idx_d == IW'(i)) begin
        dig   = bcd_q[4*i +: 4];
        blank = (BLANK_LZ != 0) && (i > 0) && zacc;
      end
    end
  end

  seg7_hex_dec u_dec (
    .hex_i (dig),
    .seg_o (hex_seg)
  );

  assign seg_d = ovf_q ? SEG_DASH : (blank ? SEG_BLANK : hex_seg);

  always_ff @(posedge clk) begin
    if (reset_p) begin
      ref_q <= '0;
      idx_q <= '0;
      com_q <= ~DIGITS'(1);
      seg_q <= HEX_SEG[0];
    end else if (ref_q == RW'(REFRESH_CNT - 1)) begin
      ref_q <= '0;
      idx_q <= idx_d;
      com_q <= com_d;
      seg_q <= seg_d;
    end else begin
      ref_q <= ref_q + 1'b1;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;
  assign bcd      = bcd_q;
  assign seg_7    = seg_q;
  assign com      = com_q;

endmodule

// File: tb/tb_fnd_bcd_scan_ctrl.sv
// Randomised self-checking bench: decimal-arithmetic reference model.
module tb_fnd_bcd_scan_ctrl;
  localparam int BIN_W = 14, DIGITS = 4, R = 4;

  logic clk = 1'b0, reset_p = 1'b1, load = 1'b0;
  logic [BIN_W-1:0] bin = '0;
  logic busy, valid, overflow, busy0, valid0, overflow0;
  logic [15:0] bcd, bcd0;
  logic [7:0]  seg_7, seg0;
  logic [3:0]  com, com0;

  fnd_bcd_scan_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS), .REFRESH_CNT(R), .BLANK_LZ(1)) dut (
    .clk(clk), .reset_p(reset_p), .bin(bin), .load(load), .busy(busy), .valid(valid),
    .overflow(overflow), .bcd(bcd), .seg_7(seg_7), .com(com));

  fnd_bcd_scan_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS), .REFRESH_CNT(R), .BLANK_LZ(0)) dut0 (
    .clk(clk), .reset_p(reset_p), .bin(bin), .load(load), .busy(busy0), .valid(valid0),
    .overflow(overflow0), .bcd(bcd0), .seg_7(seg0), .com(com0));

  always #5 clk = ~clk;

  // Cycles since reset released; digit dwell follows directly from it.
  int ncyc;
  always @(posedge clk) if (reset_p) ncyc <= 0; else ncyc <= ncyc + 1;

  int errs = 0, checks = 0;
  int pub_val = 0;
  bit pub_ovf = 1'b0;
  logic [7:0] tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic logic [15:0] to_bcd(input int v);
    int r, dv;
    logic [15:0] b;
    r = v % 10000; dv = 1; b = '0;
    for (int d = 0; d < 4; d++) begin
      b[4*d +: 4] = 4'((r / dv) % 10);
      dv *= 10;
    end
    return b;
  endfunction

  function automatic logic [7:0] exp_seg(input int d, input int v, input bit ovf, input bit blk);
    int r, dv;
    r = v % 10000; dv = 1;
    for (int k = 0; k < d; k++) dv *= 10;
    if (ovf) return 8'hBF;
    if (blk && d > 0 && (r / dv) == 0) return 8'hFF;
    return tab[(r / dv) % 10];
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (bcd !== 16'h0) begin errs++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
    checks++; if (com !== 4'b1110) begin errs++; $display("FAIL reset_com got=%b exp=1110", com); end
    checks++; if (seg_7 !== 8'hC0) begin errs++; $display("FAIL reset_seg got=%h exp=c0", seg_7); end
  endtask

  task automatic test_convert(input int v);
    int lat, bcnt, idx;
    logic [3:0] ecom;
    @(negedge clk); bin = BIN_W'(v); load = 1'b1;
    @(negedge clk); load = 1'b0; bin = BIN_W'($urandom);
    lat = 0; bcnt = 0;
    while (!valid && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk); lat++;
    end
    pub_val = v; pub_ovf = (v > 9999);
    checks++; if (lat != 15) begin errs++; $display("FAIL latency v=%0d got=%0d exp=15", v, lat); end
    checks++; if (bcnt != 15) begin errs++; $display("FAIL busy_len v=%0d got=%0d exp=15", v, bcnt); end
    checks++; if (bcd !== to_bcd(v)) begin errs++; $display("FAIL bcd v=%0d got=%h exp=%h", v, bcd, to_bcd(v)); end
    checks++; if (overflow !== pub_ovf) begin errs++; $display("FAIL ovf v=%0d got=%b exp=%b", v, overflow, pub_ovf); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errs++; $display("FAIL valid_pulse v=%0d got=%b exp=0", v, valid); end
    repeat (R) @(negedge clk);
    for (int i = 0; i < 2 * R * DIGITS; i++) begin
      idx = (ncyc / R) % DIGITS;
      ecom = ~(4'b0001 << idx);
      checks++; if (com !== ecom) begin errs++; $display("FAIL scan_com v=%0d got=%b exp=%b", v, com, ecom); end
      checks++; if (seg_7 !== exp_seg(idx, v, pub_ovf, 1'b1))
        begin errs++; $display("FAIL scan_seg v=%0d d=%0d got=%h exp=%h", v, idx, seg_7, exp_seg(idx, v, pub_ovf, 1'b1)); end
      checks++; if (seg0 !== exp_seg(idx, v, pub_ovf, 1'b0))
        begin errs++; $display("FAIL scan_seg_nb v=%0d d=%0d got=%h exp=%h", v, idx, seg0, exp_seg(idx, v, pub_ovf, 1'b0)); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) test_convert(int'($urandom_range(0, 16383)));
  endtask

  task automatic test_back_to_back();
    int q[$];
    int rem, v, nacc, nval;
    bit vexp;
    rem = 0; vexp = 1'b0; nacc = 0; nval = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      checks++; if (valid !== vexp) begin errs++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", i, valid, vexp); end
      checks++; if (busy !== (rem > 0)) begin errs++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", i, busy, rem > 0); end
      if (valid) begin
        nval++;
        if (q.size() == 0) begin
          checks++; errs++; $display("FAIL b2b_extra_valid cyc=%0d got=1 exp=0", i);
        end else begin
          v = q.pop_front();
          pub_val = v; pub_ovf = (v > 9999);
          checks++; if (bcd !== to_bcd(v)) begin errs++; $display("FAIL b2b_bcd v=%0d got=%h exp=%h", v, bcd, to_bcd(v)); end
          checks++; if (overflow !== pub_ovf) begin errs++; $display("FAIL b2b_ovf v=%0d got=%b exp=%b", v, overflow, pub_ovf); end
        end
      end
      load = (i < 45);
      if (i % 5 == 0) bin = BIN_W'($urandom_range(0, 16383));
      // One accepted request occupies 15 busy cycles; valid then frees it.
      vexp = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) vexp = 1'b1;
      end else if (load) begin
        q.push_back(int'(bin)); rem = 15; nacc++;
      end
    end
    load = 1'b0;
    checks++; if (q.size() != 0) begin errs++; $display("FAIL b2b_pending got=%0d exp=0", q.size()); end
    checks++; if (nval != nacc || nacc < 2) begin errs++; $display("FAIL b2b_count got=%0d exp=%0d", nval, nacc); end
  endtask

  task automatic test_reset_mid();
    int nv;
    @(negedge clk); bin = BIN_W'(9876); load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (6) @(negedge clk);
    reset_p = 1'b1;
    @(negedge clk); reset_p = 1'b0;
    pub_val = 0; pub_ovf = 1'b0;
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin errs++; $display("FAIL abort_valid got=%b exp=0", valid); end
    checks++; if (overflow !== 1'b0) begin errs++; $display("FAIL abort_ovf got=%b exp=0", overflow); end
    checks++; if (bcd !== 16'h0) begin errs++; $display("FAIL abort_bcd got=%h exp=0000", bcd); end
    checks++; if (com !== 4'b1110) begin errs++; $display("FAIL abort_com got=%b exp=1110", com); end
    checks++; if (seg_7 !== 8'hC0) begin errs++; $display("FAIL abort_seg got=%h exp=c0", seg_7); end
    nv = 0;
    repeat (25) begin @(negedge clk); if (valid) nv++; end
    checks++; if (nv != 0) begin errs++; $display("FAIL abort_no_valid got=%0d exp=0", nv); end
    test_convert(42);
  endtask

  initial begin
    reset_p = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_p = 1'b0;
    test_reset();
    test_convert(1234);
    test_convert(5);
    test_convert(0);
    test_convert(9999);
    test_convert(12345);
    test_random();
    test_back_to_back();
    test_convert(7);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
